game_engine: RTL and testbench
==============================

GAME_ENGINE -- requirements
Module: game_engine

Interface
REQ-001 Parameter TICK_DIV, default 833333: CLOCK_50 cycles per frame tick (60 Hz).
REQ-002 Parameter GAP_H, default 30: vertical pipe-gap height in pixels.
REQ-003 Parameter FLAP_VEL, default -4: signed velocity loaded on a flap.
REQ-004 Parameter MAX_FALL, default 4: maximum downward velocity; gravity is fixed at +1 per update.
REQ-005 Port CLOCK_50, input, 1: the only clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: the reset is synchronous and active-high.
REQ-007 Port flap, input, 1: player button, level, synchronous to CLOCK_50.
REQ-008 Port frame_done, input, 1: toggle from the painter; every change of value means erase is complete.
REQ-009 Port game_pulse, output, 1: one-cycle frame strobe to the painter.
REQ-010 Port box_y, output, 7: bird centre row; the bird occupies columns 3..5 and rows box_y-1..box_y+1.
REQ-011 Port pipe_one_x, output, 8: pipe column, 0..159.
REQ-012 Port pipe_one_y, output, 7: first row of the pipe gap.
REQ-013 Port game_over, output, 1: high while in OVER.
REQ-014 Port score, output, 8: pipes passed.

Function
REQ-015 The tick counter counts 0..TICK_DIV-1 and wraps; on wrap it issues game_pulse for exactly one cycle, except while in WAIT_DRAW, where that pulse is dropped.
REQ-016 The flap-edge detector registers flap; a 0->1 transition sets flap_pending, which holds until the next UPDATE or OVER exit consumes it.
REQ-017 The frame_done edge detector registers frame_done; done_evt is the cycle where frame_done differs from its registered copy.
REQ-018 States are IDLE, WAIT_TICK, WAIT_DRAW, UPDATE and OVER.
REQ-019 IDLE: outputs hold their reset values; flap_pending -> WAIT_TICK, consuming flap_pending.
REQ-020 WAIT_TICK: on an issued game_pulse -> WAIT_DRAW.
REQ-021 WAIT_DRAW: on done_evt -> UPDATE.
REQ-022 UPDATE lasts one cycle; all position registers are written on the edge that leaves UPDATE; the next state is OVER on collision, else WAIT_TICK.
REQ-023 Velocity is held as a signed 4-bit value: v' = FLAP_VEL when flap_pending is set, else min(v+1, MAX_FALL).
REQ-024 The bird sum is y' = box_y + v', computed in signed 8 bits; when y' < 1, box_y = 1 and v = 0.
REQ-025 When y' >= 118, box_y = 118 and the ground collision flag is set.
REQ-026 Pipe motion: when pipe_one_x = 0, the next value is 159, pipe_one_y = 8 + lfsr[5:0], the LFSR steps once, and score increments.
REQ-027 Otherwise pipe_one_x decrements by 1.
REQ-028 The LFSR is 7 bits, x^7+x^6+1, non-zero, and steps only on pipe wrap.
REQ-029 Pipe collision is asserted when the new pipe_one_x is in 3..5 and either box_y-1 < pipe_one_y or box_y+1 > pipe_one_y+GAP_H-1, both using the new values.
REQ-030 OVER: game_over = 1; positions are frozen; game_pulse continues at the tick rate.
REQ-031 OVER: on flap_pending, flap_pending is cleared, all state reinitialises to reset values, and the block enters IDLE.
REQ-032 Simultaneous done_evt and tick wrap in WAIT_DRAW: the pulse is dropped and the UPDATE transition is taken.
REQ-033 A flap edge arriving in the UPDATE cycle is kept pending for the next UPDATE.

Reset
REQ-034 Reset takes effect on the first clock edge with reset high and overrides all transitions, including mid-UPDATE.
REQ-035 Reset values: state IDLE, box_y 60, v 0, pipe_one_x 159, pipe_one_y 40, lfsr 7'h5A, score 0, game_over 0, game_pulse 0, tick counter 0, flap_pending 0.
REQ-036 After reset, the registered copy of frame_done equals the current frame_done, so no spurious done_evt occurs.

Configuration
REQ-037 Macro GAME_ENGINE_SCORE_EN defined: score is an 8-bit counter saturating at 255.
REQ-038 Macro GAME_ENGINE_SCORE_EN undefined: score is constant 0, no counter flops exist, and all other behaviour is unchanged.

Verification
REQ-039 Reset, then idle with TICK_DIV=4: game_pulse is high every 4th cycle, box_y = 60, and pipe_one_x = 159 throughout.
REQ-040 Flap, one tick, then toggle frame_done with no further flap: after UPDATE, v = 1 and box_y = 61, pipe_one_x = 158, and game_over = 0.
REQ-041 Withhold frame_done for 3 tick periods in WAIT_DRAW: no game_pulse is seen, and there is one UPDATE after the eventual toggle.
REQ-042 No flaps for repeated frames: v saturates at 4, box_y clamps to 118, then game_over = 1 and positions stay frozen.
REQ-043 Force the pipe to 0 with the LFSR at its reset value: the next UPDATE gives pipe_one_x = 159, pipe_one_y = 8 + (lfsr[5:0] as stepped per REQ-026/REQ-028 from 7'h5A), and score = 1; without the macro, score = 0.
REQ-044 pipe_one_x reaches 5 with box_y = 20 and pipe_one_y = 40: game_over = 1 in the cycle after UPDATE; a subsequent flap edge returns the block to IDLE with reset values.

Source files
------------

// File: rtl/game_engine.sv
// game_engine: frame-tick driven flappy-bird style game core.
// Sequences one position update per frame: waits for a frame tick, hands the
// frame to the painter, waits for the painter's erase-complete toggle, then
// moves the bird and pipe and checks for collisions.
//
// Ports:
//   CLOCK_50    in   1  sole clock, rising edge
//   reset       in   1  synchronous, active-high
//   flap        in   1  player button level (rising edge = flap)
//   frame_done  in   1  painter toggle; any change means erase is complete
//   game_pulse  out  1  one-cycle frame strobe to the painter
//   box_y       out  7  bird centre row (bird spans rows box_y-1..box_y+1)
//   pipe_one_x  out  8  pipe column, 0..159
//   pipe_one_y  out  7  first row of the pipe gap
//   game_over   out  1  high while the game is over
//   score       out  8  pipes passed
//
// Build option: define GAME_ENGINE_SCORE_EN to get a saturating score
// counter; without it score is tied to zero and no counter exists.
module game_engine #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned GAP_H    = 30,
    parameter int          FLAP_VEL = -4,
    parameter int unsigned MAX_FALL = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       flap,
    input  logic       frame_done,
    output logic       game_pulse,
    output logic [6:0] box_y,
    output logic [7:0] pipe_one_x,
    output logic [6:0] pipe_one_y,
    output logic       game_over,
    output logic [7:0] score
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic signed [3:0] FLAP_S   = 4'(FLAP_VEL);
    localparam logic signed [3:0] MAX_S    = 4'(MAX_FALL);
    localparam logic        [6:0] Y_RESET  = 7'd60;
    localparam logic        [7:0] X_RESET  = 8'd159;
    localparam logic        [6:0] PY_RESET = 7'd40;
    localparam logic        [6:0] LFSR_RST = 7'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_WAIT_DRAW,
        S_UPDATE,
        S_OVER
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic signed [3:0] vel;
    logic        [6:0] lfsr;
    logic              flap_q;
    logic              done_q;
    logic              flap_pending;

    logic              tick_wrap;
    logic              flap_rise;
    logic              done_evt;

    // Next-position datapath, only committed on the edge leaving UPDATE
    logic signed [3:0] vel_cand;
    logic signed [7:0] y_sum;
    logic        [6:0] box_nx;
    logic signed [3:0] vel_nx;
    logic              ground_hit;
    logic        [6:0] lfsr_step;
    logic        [7:0] px_nx;
    logic        [6:0] py_nx;
    logic        [6:0] lfsr_nx;
    logic        [8:0] bird_top;
    logic        [8:0] bird_bot;
    logic        [8:0] gap_lo;
    logic        [8:0] gap_hi;
    logic              pipe_hit;

    assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign flap_rise = flap & ~flap_q;
    assign done_evt  = frame_done ^ done_q;

    // x^7 + x^6 + 1 Fibonacci step
    assign lfsr_step = {lfsr[5:0], lfsr[6] ^ lfsr[5]};

    // Bird physics: flap, gravity with terminal velocity, ceiling and ground
    always_comb begin
        vel_cand   = FLAP_S;
        y_sum      = 8'sd0;
        box_nx     = box_y;
        vel_nx     = vel;
        ground_hit = 1'b0;

        if (flap_pending) begin
            vel_cand = FLAP_S;
        end else if (vel >= MAX_S) begin
            vel_cand = MAX_S;
        end else begin
            vel_cand = vel + 4'sd1;
        end

        y_sum = $signed({1'b0, box_y}) + $signed({{4{vel_cand[3]}}, vel_cand});

        if (y_sum < 8'sd1) begin
            box_nx = 7'd1;
            vel_nx = 4'sd0;
        end else if (y_sum >= 8'sd118) begin
            box_nx     = 7'd118;
            vel_nx     = vel_cand;
            ground_hit = 1'b1;
        end else begin
            box_nx = y_sum[6:0];
            vel_nx = vel_cand;
        end
    end

    // Pipe scroll and respawn with a pseudo-random gap row
    always_comb begin
        px_nx   = pipe_one_x - 8'd1;
        py_nx   = pipe_one_y;
        lfsr_nx = lfsr;
        if (pipe_one_x == 8'd0) begin
            px_nx   = X_RESET;
            py_nx   = 7'd8 + {1'b0, lfsr_step[5:0]};
            lfsr_nx = lfsr_step;
        end
    end

    // Pipe collision against the freshly computed bird and pipe positions
    always_comb begin
        bird_top = {2'b00, box_nx} - 9'd1;
        bird_bot = {2'b00, box_nx} + 9'd1;
        gap_lo   = {2'b00, py_nx};
        gap_hi   = gap_lo + 9'(GAP_H) - 9'd1;
        pipe_hit = (px_nx >= 8'd3) && (px_nx <= 8'd5) &&
                   ((bird_top < gap_lo) || (bird_bot > gap_hi));
    end

    // Game sequencer, tick divider and input edge detectors
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            game_pulse   <= 1'b0;
            box_y        <= Y_RESET;
            vel          <= 4'sd0;
            pipe_one_x   <= X_RESET;
            pipe_one_y   <= PY_RESET;
            lfsr         <= LFSR_RST;
            game_over    <= 1'b0;
            flap_pending <= 1'b0;
            // Seed with the live inputs so reset release never looks like an edge
            flap_q       <= flap;
            done_q       <= frame_done;
        end else begin
            flap_q       <= flap;
            done_q       <= frame_done;
            tick_cnt     <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
            // The painter is busy in WAIT_DRAW, so that frame's strobe is skipped
            game_pulse   <= tick_wrap && (state != S_WAIT_DRAW);
            flap_pending <= flap_pending | flap_rise;

            case (state)
                S_IDLE: begin
                    if (flap_pending) begin
                        state        <= S_WAIT_TICK;
                        flap_pending <= flap_rise;
                    end
                end
                S_WAIT_TICK: begin
                    if (tick_wrap) begin
                        state <= S_WAIT_DRAW;
                    end
                end
                S_WAIT_DRAW: begin
                    if (done_evt) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    box_y        <= box_nx;
                    vel          <= vel_nx;
                    pipe_one_x   <= px_nx;
                    pipe_one_y   <= py_nx;
                    lfsr         <= lfsr_nx;
                    // A flap landing in this cycle survives for the next update
                    flap_pending <= flap_rise;
                    game_over    <= ground_hit | pipe_hit;
                    state        <= (ground_hit | pipe_hit) ? S_OVER : S_WAIT_TICK;
                end
                S_OVER: begin
                    if (flap_pending) begin
                        state        <= S_IDLE;
                        tick_cnt     <= '0;
                        game_pulse   <= 1'b0;
                        box_y        <= Y_RESET;
                        vel          <= 4'sd0;
                        pipe_one_x   <= X_RESET;
                        pipe_one_y   <= PY_RESET;
                        lfsr         <= LFSR_RST;
                        game_over    <= 1'b0;
                        flap_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GAME_ENGINE_SCORE_EN
    // Pipes passed, saturating; counts on each pipe respawn
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            score <= 8'd0;
        end else if ((state == S_OVER) && flap_pending) begin
            score <= 8'd0;
        end else if ((state == S_UPDATE) && (pipe_one_x == 8'd0) && (score != 8'd255)) begin
            score <= score + 8'd1;
        end
    end
`else
    assign score = 8'd0;
`endif

endmodule

// File: tb/tb_game_engine.sv
// tb_game_engine: directed bench for game_engine with a four-cycle frame tick.
// A frame table with hand-derived positions drives the opening frames; a small
// bird/pipe reference model tracks the longer runs and the corner sequences.
module tb_game_engine;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       flap;
    logic       frame_done;
    logic       game_pulse;
    logic [6:0] box_y;
    logic [7:0] pipe_one_x;
    logic [6:0] pipe_one_y;
    logic       game_over;
    logic [7:0] score;

    game_engine #(
        .TICK_DIV(TICK),
        .GAP_H   (30),
        .FLAP_VEL(-4),
        .MAX_FALL(4)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .flap      (flap),
        .frame_done(frame_done),
        .game_pulse(game_pulse),
        .box_y     (box_y),
        .pipe_one_x(pipe_one_x),
        .pipe_one_y(pipe_one_y),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_y;
    int         m_v;
    int         m_px;
    int         m_py;
    int         m_score;
    logic [6:0] m_lfsr;
    bit         m_over;
    bit         carry;

    typedef struct {
        bit fl;
        int y;
        int px;
        bit over;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y     = 60;
        m_v     = 0;
        m_px    = 159;
        m_py    = 40;
        m_lfsr  = 7'h5A;
        m_score = 0;
        m_over  = 1'b0;
        carry   = 1'b0;
    endtask

    task automatic model_update(input bit fl);
        int  nv;
        int  ny;
        bit  ground;
        bit  hit;
        nv     = fl ? -4 : ((m_v >= 4) ? 4 : m_v + 1);
        ny     = m_y + nv;
        ground = 1'b0;
        if (ny < 1) begin
            m_y = 1;
            m_v = 0;
        end else if (ny >= 118) begin
            m_y    = 118;
            m_v    = nv;
            ground = 1'b1;
        end else begin
            m_y = ny;
            m_v = nv;
        end
        if (m_px == 0) begin
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            m_px   = 159;
            m_py   = 8 + int'(m_lfsr[5:0]);
`ifdef GAME_ENGINE_SCORE_EN
            if (m_score < 255) m_score++;
`endif
        end else begin
            m_px = m_px - 1;
        end
        hit    = (m_px >= 3) && (m_px <= 5) && ((m_y - 1 < m_py) || (m_y + 1 > m_py + 29));
        m_over = ground || hit;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".box_y"},      int'(box_y),      m_y);
        check({tag, ".pipe_one_x"}, int'(pipe_one_x), m_px);
        check({tag, ".pipe_one_y"}, int'(pipe_one_y), m_py);
        check({tag, ".game_over"},  int'(game_over),  int'(m_over));
        check({tag, ".score"},      int'(score),      m_score);
    endtask

    // Wait (bounded) for a game_pulse; optionally press flap on the first cycle
    task automatic wait_pulse(input bit fl, output bit got);
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            flap = (i == 0) ? fl : 1'b0;
            if (game_pulse) got = 1'b1;
        end
        check("pulse_seen", int'(got), 1);
    endtask

    task automatic do_frame(input bit fl, input string tag);
        bit got;
        wait_pulse(fl, got);
        frame_done = ~frame_done;
        @(negedge clk);
        flap = 1'b0;
        @(negedge clk);
        model_update(fl | carry);
        carry = 1'b0;
        check_model(tag);
    endtask

    // Align to a tick so the IDLE exit completes well before the next wrap
    task automatic start_game();
        bit got;
        wait_pulse(1'b0, got);
        flap = 1'b1;
        @(negedge clk);
        flap = 1'b0;
        @(negedge clk);
    endtask

    // Observe 12 cycles while game over: pulses keep coming, nothing moves
    task automatic check_frozen(input string tag);
        int pulses = 0;
        int moved  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) frame_done = ~frame_done;
            pulses += int'(game_pulse);
            if (int'(box_y) != m_y || int'(pipe_one_x) != m_px || int'(pipe_one_y) != m_py) moved++;
        end
        check({tag, ".pulses"}, pulses, 3);
        check({tag, ".moved"},  moved,  0);
        check({tag, ".over"},   int'(game_over), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        int frames;
        int pulses;
        int gap_errs;
        int last;
        int drift;
        int stray;
        int moved;

        tbl[0] = '{1'b0, 61, 158, 1'b0};
        tbl[1] = '{1'b0, 63, 157, 1'b0};
        tbl[2] = '{1'b1, 59, 156, 1'b0};
        tbl[3] = '{1'b0, 56, 155, 1'b0};
        tbl[4] = '{1'b0, 54, 154, 1'b0};
        tbl[5] = '{1'b0, 53, 153, 1'b0};
        tbl[6] = '{1'b0, 53, 152, 1'b0};
        tbl[7] = '{1'b0, 54, 151, 1'b0};

        reset      = 1'b1;
        flap       = 1'b0;
        frame_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_model("reset");
        check("reset.game_pulse", int'(game_pulse), 0);

        // Idle: tick strobe every 4th cycle, positions parked
        pulses   = 0;
        gap_errs = 0;
        last     = 0;
        drift    = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (game_pulse) begin
                pulses++;
                if (i - last != TICK) gap_errs++;
                last = i;
            end
            if (box_y != 7'd60 || pipe_one_x != 8'd159) drift++;
        end
        check("idle.pulse_count", pulses, 4);
        check("idle.pulse_gap_errs", gap_errs, 0);
        check("idle.drift", drift, 0);

        // Game A: opening frames from the table
        start_game();
        for (int i = 0; i < 8; i++) begin
            do_frame(tbl[i].fl, "tbl_model");
            check("tbl.box_y",      int'(box_y),      tbl[i].y);
            check("tbl.pipe_one_x", int'(pipe_one_x), tbl[i].px);
            check("tbl.game_over",  int'(game_over),  int'(tbl[i].over));
        end

        // Painter holds frame_done for three tick periods in WAIT_DRAW
        wait_pulse(1'b0, got);
        stray = 0;
        moved = 0;
        for (int i = 0; i < 3 * TICK; i++) begin
            @(negedge clk);
            stray += int'(game_pulse);
            if (int'(pipe_one_x) != m_px) moved++;
        end
        check("hold.no_pulse", stray, 0);
        check("hold.frozen", moved, 0);
        frame_done = ~frame_done;
        repeat (2) @(negedge clk);
        model_update(1'b0);
        check_model("hold_update");
        check("hold.single_step_px", int'(pipe_one_x), 150);
        check("hold.single_step_y",  int'(box_y),      56);

        // done_evt coincides with a tick wrap in WAIT_DRAW
        wait_pulse(1'b0, got);
        repeat (TICK - 1) @(negedge clk);
        frame_done = ~frame_done;
        @(negedge clk);
        check("coincide.pulse_dropped", int'(game_pulse), 0);
        @(negedge clk);
        model_update(1'b0);
        check_model("coincide");
        check("coincide.px", int'(pipe_one_x), 149);

        // Flap edge during the UPDATE cycle carries into the next update
        wait_pulse(1'b0, got);
        frame_done = ~frame_done;
        @(negedge clk);
        flap = 1'b1;
        @(negedge clk);
        flap = 1'b0;
        model_update(1'b0);
        check_model("late_flap_a");
        check("late_flap.y_a", int'(box_y), 63);
        carry = 1'b1;
        do_frame(1'b0, "late_flap_b");
        check("late_flap.y_b", int'(box_y), 59);

        // Steer high and fly into the pipe's upper section
        frames = 0;
        while (!m_over && frames < 200) begin
            do_frame(m_y >= 22, "steer_high");
            frames++;
        end
        check("hit.pipe_one_x", int'(pipe_one_x), 5);
        check("hit.game_over", int'(game_over), 1);
        check("hit.bird_above_gap", int'(box_y < 7'd40), 1);
        check_frozen("hit_frozen");

        // Flap out of game over back to IDLE with reset values
        @(negedge clk);
        flap = 1'b1;
        @(negedge clk);
        flap = 1'b0;
        @(negedge clk);
        model_reset();
        check_model("over_exit");

        // Game B: fly through the gap until the pipe respawns
        start_game();
        for (int i = 0; i < 160; i++) begin
            do_frame(m_y >= 55, "cruise");
        end
        check("wrap.pipe_one_x", int'(pipe_one_x), 159);
        check("wrap.pipe_one_y", int'(pipe_one_y), 61);
`ifdef GAME_ENGINE_SCORE_EN
        check("wrap.score", int'(score), 1);
`else
        check("wrap.score", int'(score), 0);
`endif
        do_frame(m_y >= 55, "cruise_post");
        do_frame(m_y >= 55, "cruise_post");

        // Reset asserted during the UPDATE cycle wins
        wait_pulse(1'b0, got);
        frame_done = ~frame_done;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_model("reset_mid_update");

        // Game C: free fall to the ground
        start_game();
        frames = 0;
        while (!m_over && frames < 40) begin
            do_frame(1'b0, "fall");
            frames++;
        end
        check("ground.box_y", int'(box_y), 118);
        check("ground.game_over", int'(game_over), 1);
        check("ground.pipe_one_x", int'(pipe_one_x), 143);
        check_frozen("ground_frozen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
